alu_16bit: RTL and testbench

Registered 16-bit ALU: a single-cycle datapath of arithmetic, logic, shift and rotate operations, selected by a 4-bit opcode, with a registered result and four status flags. It is the execution stage of the CPU datapath. The opcode constants `OP_*` come from the shared `alu_pkg`. Arithmetic is done in a dedicated adder submodule instance, `u_arithmetic_unit`.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_arith.sv | 45 ++++
 rtl/alu_16bit.sv | 97 +++++++++
 tb/tb_alu_16bit.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU constants: datapath width and opcode encoding.
package alu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned OP_W   = 4;

    localparam logic [OP_W-1:0] OP_ADD   = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SUB   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_AND   = OP_W'(2);
    localparam logic [OP_W-1:0] OP_OR    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_NOT   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SHL   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SHR   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_SAR   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_ROL   = OP_W'(9);
    localparam logic [OP_W-1:0] OP_ROR   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_INC   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_DEC   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_CMP   = OP_W'(13);
    localparam logic [OP_W-1:0] OP_PASSA = OP_W'(14);
    localparam logic [OP_W-1:0] OP_PASSB = OP_W'(15);

endpackage

// File: rtl/alu_arith.sv
// Shared adder for ADD/SUB/CMP/INC/DEC: {cout,sum} = a + b_mux + cin_mux.
module alu_arith
    import alu_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ovf
);

    logic [DATA_W-1:0] b_mux;
    logic              cin_mux;

    // Subtraction is a + ~b + carry, so Cin acts as not-borrow.
    always_comb begin
        b_mux   = b;
        cin_mux = cin;
        case (op)
            OP_SUB: begin
                b_mux   = ~b;
                cin_mux = cin;
            end
            OP_CMP: begin
                b_mux   = ~b;
                cin_mux = 1'b1;
            end
            OP_INC: begin
                b_mux   = '0;
                cin_mux = 1'b1;
            end
            OP_DEC: begin
                b_mux   = '1;
                cin_mux = 1'b0;
            end
            default: ;
        endcase
    end

    assign {cout, sum} = (DATA_W+1)'(a) + (DATA_W+1)'(b_mux) + (DATA_W+1)'(cin_mux);
    assign ovf = (a[DATA_W-1] == b_mux[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);

endmodule

// File: rtl/alu_16bit.sv
// Registered 16-bit ALU execution stage: one operation per enabled clock edge,
// result and Z/C/V/N flags registered.
module alu_16bit
    import alu_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   OpCode,
    input  logic              Cin,
    output logic [DATA_W-1:0] Result,
    output logic              Zero,
    output logic              Carry,
    output logic              Overflow,
    output logic              Negative
);

    localparam int unsigned MSB = DATA_W - 1;

    logic [DATA_W-1:0] arith_sum;
    logic              arith_cout;
    logic              arith_ovf;

    logic [DATA_W-1:0] res_c;
    logic              carry_c;
    logic              ovf_c;

    alu_arith u_arithmetic_unit (
        .a    (A),
        .b    (B),
        .op   (OpCode),
        .cin  (Cin),
        .sum  (arith_sum),
        .cout (arith_cout),
        .ovf  (arith_ovf)
    );

    // Next result and carry/overflow per opcode.
    always_comb begin
        res_c   = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (OpCode)
            OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC: begin
                res_c   = arith_sum;
                carry_c = arith_cout;
                ovf_c   = arith_ovf;
            end
            OP_AND:   res_c = A & B;
            OP_OR:    res_c = A | B;
            OP_XOR:   res_c = A ^ B;
            OP_NOT:   res_c = ~A;
            OP_SHL: begin
                res_c   = {A[MSB-1:0], 1'b0};
                carry_c = A[MSB];
            end
            OP_SHR: begin
                res_c   = {1'b0, A[MSB:1]};
                carry_c = A[0];
            end
            OP_SAR: begin
                res_c   = {A[MSB], A[MSB:1]};
                carry_c = A[0];
            end
            OP_ROL: begin
                res_c   = {A[MSB-1:0], A[MSB]};
                carry_c = A[MSB];
            end
            OP_ROR: begin
                res_c   = {A[0], A[MSB:1]};
                carry_c = A[0];
            end
            OP_PASSA: res_c = A;
            OP_PASSB: res_c = B;
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            Result   <= '0;
            Zero     <= 1'b0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Negative <= 1'b0;
        end else if (EN) begin
            Result   <= res_c;
            Zero     <= (res_c == '0);
            Carry    <= carry_c;
            Overflow <= ovf_c;
            Negative <= res_c[MSB];
        end
    end

endmodule

// File: tb/tb_alu_16bit.sv
// Self-checking bench for alu_16bit: arithmetic-level reference model compared
// every cycle, plus hand-computed literal vectors.
module tb_alu_16bit;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic        EN;
    logic [15:0] A;
    logic [15:0] B;
    logic [3:0]  OpCode;
    logic        Cin;
    logic [15:0] Result;
    logic        Zero;
    logic        Carry;
    logic        Overflow;
    logic        Negative;

    int n_vec = 0;
    int n_err = 0;

    logic [15:0] m_res;
    logic [3:0]  m_flg;

    alu_16bit dut (
        .CLK      (CLK),
        .RST      (RST),
        .EN       (EN),
        .A        (A),
        .B        (B),
        .OpCode   (OpCode),
        .Cin      (Cin),
        .Result   (Result),
        .Zero     (Zero),
        .Carry    (Carry),
        .Overflow (Overflow),
        .Negative (Negative)
    );

    always #5 CLK = ~CLK;

    // Reference: integer arithmetic; returns {Z,C,V,N,result}.
    function automatic logic [19:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic cin);
        int ua, ub, sa, sb, u, s, c;
        logic [15:0] r;
        logic cy, ov;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        c  = cin ? 1 : 0;
        cy = 1'b0;
        ov = 1'b0;
        r  = '0;
        case (op)
            OP_ADD: begin u = ua + ub + c; s = sa + sb + c; cy = (u > 65535); end
            OP_SUB: begin u = ua - ub - (1 - c); s = sa - sb - (1 - c); cy = (u >= 0); end
            OP_CMP: begin u = ua - ub; s = sa - sb; cy = (u >= 0); end
            OP_INC: begin u = ua + 1; s = sa + 1; cy = (u > 65535); end
            OP_DEC: begin u = ua - 1; s = sa - 1; cy = (u >= 0); end
            default: begin u = 0; s = 0; end
        endcase
        if (op inside {OP_ADD, OP_SUB, OP_CMP, OP_INC, OP_DEC}) begin
            r  = 16'(u);
            ov = (s > 32767) || (s < -32768);
        end else begin
            case (op)
                OP_AND:   r = a & b;
                OP_OR:    r = a | b;
                OP_XOR:   r = a ^ b;
                OP_NOT:   r = ~a;
                OP_SHL:   begin r = 16'((ua * 2) % 65536); cy = (ua >= 32768); end
                OP_SHR:   begin r = 16'(ua / 2); cy = (ua % 2 == 1); end
                OP_SAR:   begin r = 16'(ua / 2 + ((ua >= 32768) ? 32768 : 0)); cy = (ua % 2 == 1); end
                OP_ROL:   begin r = 16'((ua * 2) % 65536 + ua / 32768); cy = (ua >= 32768); end
                OP_ROR:   begin r = 16'(ua / 2 + (ua % 2) * 32768); cy = (ua % 2 == 1); end
                OP_PASSA: r = a;
                OP_PASSB: r = b;
                default:  r = '0;
            endcase
        end
        return {(r == 16'h0000), cy, ov, r[15], r};
    endfunction

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            m_res <= '0;
            m_flg <= '0;
        end else if (EN) begin
            {m_flg, m_res} <= model(OpCode, A, B, Cin);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge CLK) begin
        if (RST !== 1'bx)
            chk("model", {12'h0, Zero, Carry, Overflow, Negative, Result},
                {12'h0, m_flg, m_res});
    end

    task automatic apply(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic en);
        @(negedge CLK);
        OpCode = op;
        A      = a;
        B      = b;
        Cin    = cin;
        EN     = en;
    endtask

    task automatic lit(input string name, input logic [15:0] res, input logic [3:0] flg);
        @(posedge CLK);
        #1;
        chk(name, {12'h0, Zero, Carry, Overflow, Negative, Result}, {12'h0, flg, res});
    endtask

    logic [15:0] pat [6] = '{16'h0000, 16'hFFFF, 16'h7FFF, 16'h8000, 16'h1234, 16'hA5C3};

    initial begin
        RST = 1'b1; EN = 1'b0; A = '0; B = '0; OpCode = '0; Cin = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset", {12'h0, Zero, Carry, Overflow, Negative, Result}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        // Pin the model with hand-computed vectors; flags are {Z,C,V,N}.
        apply(OP_SUB, 16'h5678, 16'h1234, 1'b1, 1'b1);
        #1;
        chk("b_mux", {16'h0, dut.u_arithmetic_unit.b_mux}, 32'h0000EDCB);
        chk("cin_mux_sum_cout", {15'h0, dut.u_arithmetic_unit.cin_mux,
            dut.u_arithmetic_unit.cout, dut.u_arithmetic_unit.sum}, {15'h0, 1'b1, 1'b1, 16'h4444});
        lit("sub_basic", 16'h4444, 4'b0100);
        apply(OP_SUB, 16'h0000, 16'h0001, 1'b1, 1'b1);  lit("sub_borrow",  16'hFFFF, 4'b0001);
        apply(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b1);  lit("add_ovf",     16'h8000, 4'b0011);
        apply(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b1);  lit("add_wrap",    16'h0000, 4'b1100);
        apply(OP_CMP, 16'h1234, 16'h1234, 1'b0, 1'b1);  lit("cmp_eq",      16'h0000, 4'b1100);
        apply(OP_SHL, 16'h8001, 16'h0000, 1'b0, 1'b1);  lit("shl",         16'h0002, 4'b0100);
        apply(OP_ROR, 16'h0001, 16'h0000, 1'b0, 1'b1);  lit("ror",         16'h8000, 4'b0101);
        apply(OP_INC, 16'hFFFF, 16'h0000, 1'b0, 1'b1);  lit("inc_wrap",    16'h0000, 4'b1100);
        apply(OP_DEC, 16'h8000, 16'h0000, 1'b1, 1'b1);  lit("dec_ovf",     16'h7FFF, 4'b0110);
        apply(OP_SAR, 16'h8003, 16'h0000, 1'b0, 1'b1);  lit("sar",         16'hC001, 4'b0101);
        apply(OP_AND, 16'hF0F0, 16'hFF00, 1'b0, 1'b1);  lit("and_load",    16'hF000, 4'b0001);
        apply(OP_ADD, 16'h0001, 16'h0001, 1'b1, 1'b0);  lit("hold1",       16'hF000, 4'b0001);
        apply(OP_NOT, 16'h0000, 16'h0000, 1'b0, 1'b0);  lit("hold2",       16'hF000, 4'b0001);
        apply(OP_SUB, 16'h0000, 16'h0005, 1'b0, 1'b0);  lit("hold3",       16'hF000, 4'b0001);

        // Opcode sweep over boundary operands, checked by the model each cycle.
        for (int op = 0; op < 16; op++)
            for (int i = 0; i < 6; i++)
                apply(4'(op), pat[i], pat[(i + 3) % 6], 1'((op + i) % 2), 1'b1);

        // Asynchronous reset between edges discards the in-flight result.
        apply(OP_ADD, 16'h1111, 16'h2222, 1'b0, 1'b1);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        chk("async_rst", {12'h0, Zero, Carry, Overflow, Negative, Result}, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        EN  = 1'b0;
        lit("rst_hold", 16'h0000, 4'b0000);
        apply(OP_PASSB, 16'h0000, 16'h8000, 1'b0, 1'b1); lit("passb_after_rst", 16'h8000, 4'b0001);

        @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
